// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu between two requesters.
// Operands are captured on grant, executed for one cycle, and returned on a tagged response channel.

module alu #(
  parameter int WIDTH = 4
) (
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             overflow,
  output logic             negative,
  output logic             zero
);
  localparam logic [3:0] ADD_OP      = 4'd0;
  localparam logic [3:0] SUB_OP      = 4'd1;
  localparam logic [3:0] AND_OP      = 4'd2;
  localparam logic [3:0] OR_OP       = 4'd3;
  localparam logic [3:0] XOR_OP      = 4'd4;
  localparam logic [3:0] NOT_OP      = 4'd5;
  localparam logic [3:0] LL_SHIFT_OP = 4'd6;
  localparam logic [3:0] LR_SHIFT_OP = 4'd7;
  localparam logic [3:0] AR_SHIFT_OP = 4'd8;
  localparam int M = WIDTH - 1;

  always_comb begin
    y        = '0;
    cout     = 1'b0;
    overflow = 1'b0;
    case (opcode)
      ADD_OP: begin
        {cout, y} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        overflow  = (a[M] == b[M]) && (y[M] != a[M]);
      end
      SUB_OP: begin
        // cout is the borrow out
        {cout, y} = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        overflow  = (a[M] != b[M]) && (y[M] != a[M]);
      end
      AND_OP:      y = a & b;
      OR_OP:       y = a | b;
      XOR_OP:      y = a ^ b;
      NOT_OP:      y = ~a;
      LL_SHIFT_OP: y = a << b;
      LR_SHIFT_OP: y = a >> b;
      AR_SHIFT_OP: y = $signed(a) >>> b;
      default:     y = '0;
    endcase
    negative = y[M];
    zero     = (y == '0);
  end
endmodule

module alu_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_opcode,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_opcode,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_y,
  output logic             resp_cout,
  output logic             resp_overflow,
  output logic             resp_negative,
  output logic             resp_zero,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_next;
  logic             grant, last_grant, id_r, accept;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic             cin_r;
  logic [WIDTH-1:0] alu_y;
  logic             alu_cout, alu_overflow, alu_negative, alu_zero;

  alu #(.WIDTH(WIDTH)) u_alu (
    .opcode  (op_r),
    .a       (a_r),
    .b       (b_r),
    .cin     (cin_r),
    .y       (alu_y),
    .cout    (alu_cout),
    .overflow(alu_overflow),
    .negative(alu_negative),
    .zero    (alu_zero)
  );

  always_comb begin
    state_next = state;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else                          grant = req1_valid;
    // Ready is withheld under reset so a requester never sees a handshake that is not captured.
    req0_ready = (state == IDLE) && !rst && req0_valid && !grant;
    req1_ready = (state == IDLE) && !rst && req1_valid && grant;
    accept     = req0_ready || req1_ready;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      id_r          <= 1'b0;
      op_r          <= '0;
      a_r           <= '0;
      b_r           <= '0;
      cin_r         <= 1'b0;
      resp_valid    <= 1'b0;
      resp_id       <= 1'b0;
      resp_y        <= '0;
      resp_cout     <= 1'b0;
      resp_overflow <= 1'b0;
      resp_negative <= 1'b0;
      resp_zero     <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_r       <= grant ? req1_opcode : req0_opcode;
        a_r        <= grant ? req1_a : req0_a;
        b_r        <= grant ? req1_b : req0_b;
        cin_r      <= grant ? req1_cin : req0_cin;
        id_r       <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) begin
        resp_valid    <= 1'b1;
        resp_id       <= id_r;
        resp_y        <= alu_y;
        resp_cout     <= alu_cout;
        resp_overflow <= alu_overflow;
        resp_negative <= alu_negative;
        resp_zero     <= alu_zero;
      end else if (state == RESP && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a per-cycle monitor compares the DUT against a
// queue of responses predicted from grant rules and an integer ALU model.

module tb_alu_arbiter;
  localparam int OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_OR = 3, OP_XOR = 4;
  localparam int OP_NOT = 5, OP_LL = 6, OP_LR = 7, OP_AR = 8;

  typedef struct {int due; int id; int y; int cout; int ovf; int neg; int zero;} rsp_t;

  logic       clk = 0, rst = 1;
  logic       req0_valid = 0, req1_valid = 0, req0_cin = 0, req1_cin = 0;
  logic [3:0] req0_opcode = 0, req1_opcode = 0, req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic       resp_ready = 0;
  logic       req0_ready, req1_ready, resp_valid, resp_id, resp_cout, resp_overflow;
  logic       resp_negative, resp_zero, busy;
  logic [3:0] resp_y;

  alu_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_y(resp_y),
    .resp_cout(resp_cout), .resp_overflow(resp_overflow), .resp_negative(resp_negative),
    .resp_zero(resp_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic rsp_t model(input int op, input int a, input int b, input int cin);
    rsp_t r;
    int sa, sb, s, ss;
    r = '{default: 0};
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    case (op)
      OP_ADD: begin
        s = a + b + cin; ss = sa + sb + cin;
        r.y = s % 16; r.cout = (s >= 16); r.ovf = (ss > 7 || ss < -8);
      end
      OP_SUB: begin
        s = a - b - cin; ss = sa - sb - cin;
        r.y = (s + 16) % 16; r.cout = (s < 0); r.ovf = (ss > 7 || ss < -8);
      end
      OP_AND: r.y = a & b;
      OP_OR:  r.y = a | b;
      OP_XOR: r.y = a ^ b;
      OP_NOT: r.y = 15 - a;
      OP_LL:  r.y = (a << b) & 15;
      OP_LR:  r.y = a >> b;
      OP_AR:  r.y = (sa >>> b) & 15;
      default: r.y = 0;
    endcase
    r.neg  = (r.y >= 8);
    r.zero = (r.y == 0);
    return r;
  endfunction

  rsp_t exp_q[$];
  rsp_t log_q[$];
  int   hs_cyc[$];
  int   model_last = 1;
  logic prev_valid = 0, prev_ready = 0, prev_id = 0;
  logic [3:0] prev_y = 0;
  logic [3:0] prev_flags = 0;

  always @(negedge clk) begin : monitor
    rsp_t e, g;
    int n, exp_n;
    if (rst) begin
      exp_q.delete();
      model_last = 1;
      prev_valid = 0;
      prev_ready = 0;
    end else begin
      chk(!(req0_ready && req1_ready), "one_ready", int'(req1_ready), 0);
      if (req0_ready || req1_ready) begin
        n = int'(req1_ready);
        exp_n = (req0_valid && req1_valid) ? 1 - model_last : int'(req1_valid);
        chk(n == exp_n, "grant", n, exp_n);
        chk(busy == 0, "ready_only_idle", int'(busy), 0);
        if (n == 0) e = model(int'(req0_opcode), int'(req0_a), int'(req0_b), int'(req0_cin));
        else        e = model(int'(req1_opcode), int'(req1_a), int'(req1_b), int'(req1_cin));
        e.id = n;
        e.due = cyc + 2;
        exp_q.push_back(e);
        model_last = n;
        hs_cyc.push_back(cyc);
      end
      if (resp_valid && prev_valid && !prev_ready) begin
        chk(resp_y == prev_y, "hold_y", int'(resp_y), int'(prev_y));
        chk(resp_id == prev_id, "hold_id", int'(resp_id), int'(prev_id));
        chk({resp_cout, resp_overflow, resp_negative, resp_zero} == prev_flags, "hold_flags",
            int'({resp_cout, resp_overflow, resp_negative, resp_zero}), int'(prev_flags));
      end else if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk(0, "unexpected_resp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk(e.due == cyc, "resp_latency", cyc, e.due);
          chk(int'(resp_id) == e.id, "resp_id", int'(resp_id), e.id);
          chk(int'(resp_y) == e.y, "resp_y", int'(resp_y), e.y);
          chk(int'(resp_cout) == e.cout, "resp_cout", int'(resp_cout), e.cout);
          chk(int'(resp_overflow) == e.ovf, "resp_overflow", int'(resp_overflow), e.ovf);
          chk(int'(resp_negative) == e.neg, "resp_negative", int'(resp_negative), e.neg);
          chk(int'(resp_zero) == e.zero, "resp_zero", int'(resp_zero), e.zero);
        end
        g = '{default: 0};
        g.due = cyc; g.id = int'(resp_id); g.y = int'(resp_y);
        g.cout = int'(resp_cout); g.zero = int'(resp_zero);
        log_q.push_back(g);
      end
      if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        chk(0, "resp_missing", 0, 1);
        void'(exp_q.pop_front());
      end
      prev_valid = resp_valid;
      prev_ready = resp_ready;
      prev_id    = resp_id;
      prev_y     = resp_y;
      prev_flags = {resp_cout, resp_overflow, resp_negative, resp_zero};
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_hs(input int port);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (port == 0) ? req0_ready : req1_ready;
    end
    chk(seen, "hs_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 60 && log_q.size() < n; i++) begin
      @(posedge clk); #2;
    end
    chk(log_q.size() >= n, "resp_timeout", log_q.size(), n);
  endtask

  initial begin
    int base, hb;
    // reset state
    rst = 1; tick(); tick(); rst = 0;
    @(negedge clk);
    chk(resp_valid == 0, "rst_valid", int'(resp_valid), 0);
    chk(resp_id == 0, "rst_id", int'(resp_id), 0);
    chk(resp_y == 0, "rst_y", int'(resp_y), 0);
    chk({resp_cout, resp_overflow, resp_negative, resp_zero} == 0, "rst_flags",
        int'({resp_cout, resp_overflow, resp_negative, resp_zero}), 0);
    chk(busy == 0, "rst_busy", int'(busy), 0);
    chk(req0_ready == 0 && req1_ready == 0, "rst_ready", int'({req0_ready, req1_ready}), 0);

    // 1: single ADD on port 0
    tick();
    resp_ready = 1;
    req0_opcode = 4'(OP_ADD); req0_a = 4'b0101; req0_b = 4'b0001; req0_cin = 0; req0_valid = 1;
    wait_hs(0);
    req0_valid = 0;
    @(negedge clk);
    chk(req0_ready == 0, "t1_ready_once", int'(req0_ready), 0);
    wait_log(1);
    chk(resp_valid == 0, "t1_one_cycle", int'(resp_valid), 1'b0);
    chk(log_q[0].id == 0 && log_q[0].y == 6, "t1_y", log_q[0].y, 6);
    chk(log_q[0].cout == 0 && log_q[0].zero == 0, "t1_flags", log_q[0].cout + log_q[0].zero, 0);

    // 2: contention from reset, strict alternation
    rst = 1;
    req0_opcode = 4'(OP_AND); req0_a = 4'b1010; req0_b = 4'b0111; req0_valid = 1;
    req1_opcode = 4'(OP_XOR); req1_a = 4'b1100; req1_b = 4'b1010; req1_cin = 0; req1_valid = 1;
    tick(); tick(); rst = 0;
    base = log_q.size();
    wait_log(base + 6);
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 6; i++) begin
      chk(log_q[base+i].id == (i % 2), "t2_order", log_q[base+i].id, i % 2);
      chk(log_q[base+i].y == ((i % 2) ? 6 : 2), "t2_y", log_q[base+i].y, (i % 2) ? 6 : 2);
    end

    // 3: backpressure on port 1 SUB
    tick();
    resp_ready = 0;
    req1_opcode = 4'(OP_SUB); req1_a = 4'b0011; req1_b = 4'b0001; req1_cin = 0; req1_valid = 1;
    wait_hs(1);
    req1_valid = 0;
    req0_opcode = 4'(OP_OR); req0_valid = 1;
    for (int i = 0; i < 10 && !resp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk(resp_valid == 1, "t3_valid", int'(resp_valid), 1);
      chk(resp_y == 4'b0010, "t3_y", int'(resp_y), 2);
      chk(!req0_ready && !req1_ready, "t3_no_ready", int'({req0_ready, req1_ready}), 0);
    end
    @(posedge clk); #1;
    resp_ready = 1; req0_valid = 0;
    @(negedge clk);
    chk(resp_valid == 1, "t3_last_cycle", int'(resp_valid), 1);
    @(negedge clk);
    chk(resp_valid == 0, "t3_done", int'(resp_valid), 0);

    // 4: operand isolation after capture
    tick();
    req0_opcode = 4'(OP_LL); req0_a = 4'b0001; req0_b = 4'b0011; req0_cin = 0; req0_valid = 1;
    base = log_q.size();
    wait_hs(0);
    req0_valid = 0; req0_a = 4'b1111;
    wait_log(base + 1);
    chk(log_q[base].y == 8, "t4_y", log_q[base].y, 8);

    // 5: reset during EXEC drops the op
    tick();
    req0_opcode = 4'(OP_NOT); req0_a = 4'b1010; req0_valid = 1;
    base = log_q.size();
    wait_hs(0);
    req0_valid = 0; rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk(resp_valid == 0, "t5_no_resp", int'(resp_valid), 0);
      chk(busy == 0, "t5_busy", int'(busy), 0);
    end
    chk(log_q.size() == base, "t5_no_log", log_q.size(), base);
    tick();
    req1_opcode = 4'(OP_OR); req1_a = 4'b1000; req1_b = 4'b0100; req1_valid = 1;
    wait_hs(1);
    req1_valid = 0;
    wait_log(base + 1);
    chk(log_q[base].id == 1 && log_q[base].y == 12, "t5_next", log_q[base].y, 12);

    // 6: lone requester on port 1, back to back
    tick();
    req1_opcode = 4'(OP_AR); req1_a = 4'b1001; req1_b = 4'b0001; req1_valid = 1;
    base = log_q.size();
    hb = hs_cyc.size();
    for (int i = 0; i < 40 && hs_cyc.size() < hb + 4; i++) begin
      @(posedge clk); #2;
    end
    req1_valid = 0;
    wait_log(base + 4);
    for (int i = 0; i < 4; i++)
      chk(log_q[base+i].id == 1 && log_q[base+i].y == 12, "t6_y", log_q[base+i].y, 12);
    for (int i = 1; i < 4; i++)
      chk(hs_cyc[hb+i] - hs_cyc[hb+i-1] == 3, "t6_spacing", hs_cyc[hb+i] - hs_cyc[hb+i-1], 3);

    repeat (4) tick();
    chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
